// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - 8-requester round-robin arbiter with multi-cycle ownership.
//
// A winner is picked in IDLE by searching upward from last+1 (wrapping 7->0),
// then registered into grant/grant_code/grant_valid. The grant is held until
// the owner drops its request. Every release passes through IDLE, so there is
// always exactly one dead cycle between grants.
//
// Optional feature, enabled by defining RR_ARB_TIMEOUT_EN:
//   an owner that keeps requesting is force-released after HOLD_LIMIT
//   consecutive grant cycles, and timeout pulses for one cycle. Without the
//   macro there is no hold counter, timeout is tied low and a grant is held
//   indefinitely.
//
// Parameters:
//   HOLD_LIMIT   max consecutive grant cycles per owner (2..256), timeout build only
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[7:0]     request vector, bit i = requester i
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_code   registered binary index of the grant bit, 0 when idle
//   grant_valid  registered, high exactly when grant is non-zero
//   timeout      one-cycle pulse after an owner is preempted
module rr_arbiter8 #(
   parameter int HOLD_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_code,
   output logic       grant_valid,
   output logic       timeout
);

   if (HOLD_LIMIT < 2 || HOLD_LIMIT > 256) begin : g_bad_limit
      $error("rr_arbiter8: HOLD_LIMIT must be in 2..256");
   end

   typedef enum logic {IDLE, BUSY} state_e;

   state_e     state_q, state_d;
   logic [7:0] grant_q, grant_d;
   logic [2:0] code_q, code_d;
   logic [2:0] last_q, last_d;
   logic       valid_q, valid_d;
   logic       preempt;

   logic       win_found;
   logic [2:0] win_idx;

   // Rotating priority search: last+1 is checked first, last itself last,
   // so the previous owner has the lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         logic [2:0] cand;
         cand = last_q + 3'(k);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      code_d  = code_q;
      valid_d = valid_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_d          = 8'h00;
               grant_d[win_idx] = 1'b1;
               code_d           = win_idx;
               valid_d          = 1'b1;
               state_d          = BUSY;
            end
         end
         BUSY: begin
            // A preemption is handled exactly like a voluntary release.
            if (!req[code_q] || preempt) begin
               grant_d = 8'h00;
               code_d  = 3'd0;
               valid_d = 1'b0;
               last_d  = code_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 8'h00;
         code_q  <= 3'd0;
         valid_q <= 1'b0;
         last_q  <= 3'd7;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_LIMIT);

   logic [CW-1:0] hold_q, hold_d;
   logic          timeout_q;

   // The counter is 0 in the first grant cycle, so reaching HOLD_LIMIT-1
   // means the owner has held for HOLD_LIMIT cycles.
   assign preempt = (state_q == BUSY) && req[code_q] &&
                    (hold_q == CW'(HOLD_LIMIT - 1));

   always_comb begin
      hold_d = '0;
      if (state_q == BUSY) hold_d = hold_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= preempt;
      end
   end

   assign timeout = timeout_q;
`else
   assign preempt = 1'b0;
   assign timeout = 1'b0;
`endif

   assign grant       = grant_q;
   assign grant_code  = code_q;
   assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
module tb_rr_arbiter8;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int HL = 4;
`else
   localparam int HL = 16;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_code;
   logic       grant_valid;
   logic       timeout;

   rr_arbiter8 #(.HOLD_LIMIT(HL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_code  (grant_code),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected grant: value, code, visible length (0 = unchecked), timeout after release.
   typedef struct {
      logic [7:0] g;
      logic [2:0] c;
      int         hold;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push(int b, int hold, logic to);
      exp_t e;
      e.g    = 8'h00;
      e.g[b] = 1'b1;
      e.c    = 3'(b);
      e.hold = hold;
      e.to   = to;
      q.push_back(e);
   endfunction

   // ---------------- monitor / scoreboard ----------------
   exp_t       cur;
   bit         active = 1'b0;
   int         len    = 0;
   logic [7:0] prev_g = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         active = 1'b0;
         len    = 0;
         prev_g = 8'h00;
      end else begin
         logic [2:0] enc;
         enc = 3'd0;
         for (int i = 0; i < 8; i++) if (grant[i]) enc = 3'(i);
         chk("onehot0", 32'($onehot0(grant)), 32'd1);
         chk("code_vs_grant", 32'(grant_code), 32'(enc));
         chk("valid_vs_grant", 32'(grant_valid), 32'(|grant));
`ifndef RR_ARB_TIMEOUT_EN
         chk("timeout_tied_low", 32'(timeout), 32'd0);
`endif
         if (grant_valid && !active) begin
            if (q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_grant: got %0h, expected none", grant);
            end else begin
               cur = q.pop_front();
               chk("grant", 32'(grant), 32'(cur.g));
               chk("grant_code", 32'(grant_code), 32'(cur.c));
            end
            active = 1'b1;
            len    = 1;
         end else if (grant_valid && active) begin
            chk("no_handover", 32'(grant), 32'(prev_g));
            len++;
         end else if (!grant_valid && active) begin
            active = 1'b0;
            if (cur.hold > 0) chk("hold_len", 32'(len), 32'(cur.hold));
            chk("timeout_pulse", 32'(timeout), 32'(cur.to));
         end
         prev_g = grant;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_rise();
      int n = 0;
      while (grant_valid && n < 200) begin @(negedge clk); n++; end
      while (!grant_valid && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL wait_grant: got no grant within %0d cycles, expected one", n);
      end
   endtask

   // Owner b keeps its request for 'hold' visible grant cycles, then drops it;
   // in the following idle cycle 'after' is OR-ed into req.
   task automatic serve(int b, int hold, logic [7:0] after);
      wait_rise();
      repeat (hold - 1) @(negedge clk);
      req[b] = 1'b0;
      @(negedge clk);
      req = req | after;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_code", 32'(grant_code), 32'd0);
      chk("rst_valid", 32'(grant_valid), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      #2 rst_n = 1'b1;

      // idle with no requests
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_valid", 32'(grant_valid), 32'd0);
      end

      // all requesting: strict rotation 0..7 then 0
      req = 8'hFF;
      for (int k = 0; k <= 8; k++) begin
         push(k % 8, 3, 1'b0);
         serve(k % 8, 3, (k < 8) ? (8'h01 << (k % 8)) : 8'h00);
      end
      req = 8'h00;

      // set last=3 via requester 3, then req=0x24 -> 5 before 2
      push(3, 1, 1'b0);
      push(5, 2, 1'b0);
      push(2, 2, 1'b0);
      req = 8'h08;
      serve(3, 1, 8'h24);
      serve(5, 2, 8'h00);
      serve(2, 2, 8'h00);

      // owner 4 holds while 6 arrives mid-grant
      push(4, 3, 1'b0);
      push(6, 2, 1'b0);
      req = 8'h10;
      wait_rise();
      @(negedge clk);
      req = 8'h50;
      @(negedge clk);
      req[4] = 1'b0;
      @(negedge clk);
      serve(6, 2, 8'h00);

      // single-cycle pulse still wins, granted for exactly one cycle
      push(1, 1, 1'b0);
      req = 8'h02;
      @(negedge clk);
      req = 8'h00;
      repeat (4) @(negedge clk);

      // asynchronous reset in the middle of a grant
      push(3, 0, 1'b0);
      req = 8'h08;
      wait_rise();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_code", 32'(grant_code), 32'd0);
      chk("async_rst_valid", 32'(grant_valid), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      req = 8'h09;
      push(0, 2, 1'b0);
      push(3, 2, 1'b0);
      serve(0, 2, 8'h00);
      serve(3, 2, 8'h00);

`ifdef RR_ARB_TIMEOUT_EN
      // constant req=0x03: each owner preempted after 4 cycles; the third
      // grant is released voluntarily on the same edge, so no timeout
      push(0, 4, 1'b1);
      push(1, 4, 1'b1);
      push(0, 4, 1'b0);
      req = 8'h03;
      wait_rise();
      wait_rise();
      wait_rise();
      repeat (3) @(negedge clk);
      req = 8'h00;
`else
      // without the timeout feature a grant is held indefinitely
      push(0, 20, 1'b0);
      req = 8'h01;
      serve(0, 20, 8'h00);
`endif

      // drain
      for (int n = 0; n < 50 && (q.size() != 0 || grant_valid || active); n++)
         @(negedge clk);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
